ecdsa_verify_seq: RTL and testbench

- Sequencer for secp256k1 ECDSA signature verification. It sits directly upstream of scalar_mul and point_add and drives both.
- Given precomputed scalars u1 = z·w mod n and u2 = r·w mod n, the public key Q and the signature component r, it performs these steps in order: range checks, R1 = u1·G, R2 = u2·Q, R = R1 + R2, xR mod n, compare to r.
- Reports a single-cycle done with a valid flag and an error code.

---
 rtl/ecdsa_verify_seq.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ecdsa_verify_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecdsa_verify_seq.sv
// Purpose: sequences one secp256k1 ECDSA verify (range check, u1*G, u2*Q, add, reduce, compare).
// Latency: 2 cycles on range or point error, else 7 + two scalar_mul latencies + point_add latency.
// Backpressure: none; start is ignored while busy, and a watchdog aborts any stalled sub-block wait.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, u1, u2, r, s      request pulse, precomputed scalars, signature
//   Qx, Qy, Qinf             public key (affine) and its infinity flag
//   busy, done, valid, err   status: run in progress, result pulse, accept flag, error code
//   sm_*                     launch/result handshake with scalar_mul
//   pa_*                     launch/result handshake with point_add
module ecdsa_verify_seq #(
    parameter logic [23:0]  TIMEOUT_CYCLES = 24'd16000000,
    parameter logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798,
    parameter logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8,
    parameter logic [255:0] N  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] u1,
    input  logic [255:0] u2,
    input  logic [255:0] r,
    input  logic [255:0] s,
    input  logic [255:0] Qx,
    input  logic [255:0] Qy,
    input  logic         Qinf,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic [1:0]   err,
    output logic         sm_start,
    output logic [255:0] sm_k,
    output logic [255:0] sm_Px,
    output logic [255:0] sm_Py,
    output logic         sm_Pinf,
    input  logic         sm_done,
    input  logic [255:0] sm_X,
    input  logic [255:0] sm_Y,
    input  logic         sm_inf,
    output logic         pa_start,
    output logic [255:0] pa_x1,
    output logic [255:0] pa_y1,
    output logic [255:0] pa_x2,
    output logic [255:0] pa_y2,
    output logic         pa_inf1,
    output logic         pa_inf2,
    input  logic         pa_done,
    input  logic [255:0] pa_x3,
    input  logic [255:0] pa_y3,
    input  logic         pa_inf3
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_MUL1,
        S_W1,
        S_MUL2,
        S_W2,
        S_ADD,
        S_WA,
        S_RED,
        S_CMP,
        S_FIN
    } state_t;

    localparam logic [23:0] WDOG_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t       state;

    // Request captured at start; the input buses are free to change afterwards.
    logic [255:0] u1_q;
    logic [255:0] u2_q;
    logic [255:0] r_q;
    logic [255:0] s_q;
    logic [255:0] qx_q;
    logic [255:0] qy_q;
    logic         qinf_q;

    // R1 is kept here; R2 lives directly in the pa_*2 operand registers.
    logic [255:0] r1x_q;
    logic [255:0] r1y_q;
    logic         r1inf_q;

    // Final point x and infinity flag, and x reduced mod n.
    logic [255:0] rx_q;
    logic         rinf_q;
    logic [255:0] xr_q;

    logic [23:0]  wdog;
    logic         wdog_expired;
    logic         range_bad;

    // Only x of the sum matters for verification.
    logic         unused_pa_y3;
    assign unused_pa_y3 = ^pa_y3;

    assign wdog_expired = (wdog == WDOG_LAST);
    assign range_bad    = (r_q == 256'd0) || (r_q >= N) || (s_q == 256'd0) || (s_q >= N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            err      <= 2'd0;
            sm_start <= 1'b0;
            sm_k     <= '0;
            sm_Px    <= '0;
            sm_Py    <= '0;
            sm_Pinf  <= 1'b0;
            pa_start <= 1'b0;
            pa_x1    <= '0;
            pa_y1    <= '0;
            pa_x2    <= '0;
            pa_y2    <= '0;
            pa_inf1  <= 1'b0;
            pa_inf2  <= 1'b0;
            u1_q     <= '0;
            u2_q     <= '0;
            r_q      <= '0;
            s_q      <= '0;
            qx_q     <= '0;
            qy_q     <= '0;
            qinf_q   <= 1'b0;
            r1x_q    <= '0;
            r1y_q    <= '0;
            r1inf_q  <= 1'b0;
            rx_q     <= '0;
            rinf_q   <= 1'b0;
            xr_q     <= '0;
            wdog     <= '0;
        end else begin
            // Launch and result strobes are single-cycle unless re-armed below.
            done     <= 1'b0;
            sm_start <= 1'b0;
            pa_start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        u1_q   <= u1;
                        u2_q   <= u2;
                        r_q    <= r;
                        s_q    <= s;
                        qx_q   <= Qx;
                        qy_q   <= Qy;
                        qinf_q <= Qinf;
                        busy   <= 1'b1;
                        valid  <= 1'b0;
                        err    <= 2'd0;
                        state  <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (range_bad) begin
                        err   <= 2'd1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else if (qinf_q) begin
                        err   <= 2'd2;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        // Operands load together with the launch pulse so they
                        // are valid in the very cycle scalar_mul sees sm_start.
                        sm_start <= 1'b1;
                        sm_k     <= u1_q;
                        sm_Px    <= GX;
                        sm_Py    <= GY;
                        sm_Pinf  <= 1'b0;
                        state    <= S_MUL1;
                    end
                end

                S_MUL1: begin
                    wdog  <= '0;
                    state <= S_W1;
                end

                S_W1: begin
                    // A result in the expiry cycle still wins over the timeout.
                    if (sm_done) begin
                        r1x_q    <= sm_X;
                        r1y_q    <= sm_Y;
                        r1inf_q  <= sm_inf;
                        sm_start <= 1'b1;
                        sm_k     <= u2_q;
                        sm_Px    <= qx_q;
                        sm_Py    <= qy_q;
                        sm_Pinf  <= 1'b0;
                        state    <= S_MUL2;
                    end else if (wdog_expired) begin
                        err   <= 2'd3;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        wdog <= wdog + 24'd1;
                    end
                end

                S_MUL2: begin
                    wdog  <= '0;
                    state <= S_W2;
                end

                S_W2: begin
                    if (sm_done) begin
                        pa_start <= 1'b1;
                        pa_x1    <= r1x_q;
                        pa_y1    <= r1y_q;
                        pa_inf1  <= r1inf_q;
                        pa_x2    <= sm_X;
                        pa_y2    <= sm_Y;
                        pa_inf2  <= sm_inf;
                        state    <= S_ADD;
                    end else if (wdog_expired) begin
                        err   <= 2'd3;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        wdog <= wdog + 24'd1;
                    end
                end

                S_ADD: begin
                    wdog  <= '0;
                    state <= S_WA;
                end

                S_WA: begin
                    if (pa_done) begin
                        rx_q   <= pa_x3;
                        rinf_q <= pa_inf3;
                        state  <= S_RED;
                    end else if (wdog_expired) begin
                        err   <= 2'd3;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        wdog <= wdog + 24'd1;
                    end
                end

                S_RED: begin
                    // x < p < 2n, so one conditional subtract fully reduces mod n.
                    xr_q  <= (rx_q >= N) ? (rx_q - N) : rx_q;
                    state <= S_CMP;
                end

                S_CMP: begin
                    valid <= !rinf_q && (xr_q == r_q);
                    err   <= 2'd0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_FIN;
                end

                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecdsa_verify_seq.sv
// Purpose: self-checking bench for ecdsa_verify_seq with stub scalar_mul / point_add models.
// Latency: stubs answer a configurable number of cycles after their start pulse (0 = never).
// Backpressure: none; the bench bounds every wait and reports expired bounds as failures.
module tb_ecdsa_verify_seq;

    localparam logic [23:0]  TMO  = 24'd20;
    localparam int           TMOI = 20;
    localparam logic [255:0] GX   = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY   = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] N    = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
    localparam logic [255:0] MASK = {8{32'hA5C3_1E77}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] u1 = '0, u2 = '0, r = '0, s = '0, Qx = '0, Qy = '0;
    logic         Qinf = 1'b0;
    logic         busy, done, valid;
    logic [1:0]   err;
    logic         sm_start, sm_Pinf;
    logic [255:0] sm_k, sm_Px, sm_Py;
    logic         sm_done = 1'b0;
    logic [255:0] sm_X = '0, sm_Y = '0;
    logic         sm_inf = 1'b0;
    logic         pa_start, pa_inf1, pa_inf2;
    logic [255:0] pa_x1, pa_y1, pa_x2, pa_y2;
    logic         pa_done = 1'b0;
    logic [255:0] pa_x3 = '0, pa_y3 = '0;
    logic         pa_inf3 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    ecdsa_verify_seq #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .u1(u1), .u2(u2), .r(r), .s(s), .Qx(Qx), .Qy(Qy), .Qinf(Qinf),
        .busy(busy), .done(done), .valid(valid), .err(err),
        .sm_start(sm_start), .sm_k(sm_k), .sm_Px(sm_Px), .sm_Py(sm_Py), .sm_Pinf(sm_Pinf),
        .sm_done(sm_done), .sm_X(sm_X), .sm_Y(sm_Y), .sm_inf(sm_inf),
        .pa_start(pa_start), .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_x2(pa_x2), .pa_y2(pa_y2),
        .pa_inf1(pa_inf1), .pa_inf2(pa_inf2),
        .pa_done(pa_done), .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_inf3(pa_inf3)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_time_limit: simulation still running, required to finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- stub configuration ----------------
    int           lat1_cfg = 10, lat2_cfg = 10, lat3_cfg = 5;
    logic [255:0] rx_cfg = '0;
    bit           rinf_cfg = 0, sminf_cfg = 0;
    int           sm_calls = 0;

    // scalar_mul stub: result X = k ^ MASK, Y = ~k, inf = sminf_cfg.
    int           sm_cnt = 0;
    logic [255:0] sm_kc, sm_pxc, sm_pyc;
    always @(negedge clk) begin
        sm_done = 1'b0;
        if (rst) begin
            sm_cnt = 0;
        end else begin
            if (sm_cnt > 0) begin
                sm_cnt--;
                if (sm_cnt == 0) begin
                    sm_done = 1'b1;
                    sm_X    = sm_kc ^ MASK;
                    sm_Y    = ~sm_kc;
                    sm_inf  = sminf_cfg;
                    chk("sm_hold_k", sm_k, sm_kc);
                    chk("sm_hold_px", sm_Px, sm_pxc);
                    chk("sm_hold_py", sm_Py, sm_pyc);
                end
            end
            if (sm_start) begin
                int lat;
                lat = (sm_calls == 0) ? lat1_cfg : lat2_cfg;
                sm_calls++;
                sm_kc  = sm_k;
                sm_pxc = sm_Px;
                sm_pyc = sm_Py;
                if (lat > 0) sm_cnt = lat;
            end
        end
    end

    // point_add stub: result x = rx_cfg, inf = rinf_cfg, y arbitrary.
    int           pa_cnt = 0;
    logic [255:0] pa_x1c, pa_x2c;
    always @(negedge clk) begin
        pa_done = 1'b0;
        if (rst) begin
            pa_cnt = 0;
        end else begin
            if (pa_cnt > 0) begin
                pa_cnt--;
                if (pa_cnt == 0) begin
                    pa_done = 1'b1;
                    pa_x3   = rx_cfg;
                    pa_y3   = {8{$urandom()}};
                    pa_inf3 = rinf_cfg;
                    chk("pa_hold_x1", pa_x1, pa_x1c);
                    chk("pa_hold_x2", pa_x2, pa_x2c);
                end
            end
            if (pa_start) begin
                pa_x1c = pa_x1;
                pa_x2c = pa_x2;
                if (lat3_cfg > 0) pa_cnt = lat3_cfg;
            end
        end
    end

    // ---------------- vectors and reference model ----------------
    typedef struct {
        logic [255:0] u1, u2, r, s, qx, qy;
        bit           qinf;
        int           lat1, lat2, lat3;
        logic [255:0] rx;
        bit           rinf, sminf;
        int           inj;      // cycle offset of an extra start pulse, 0 = none
        bit           has_exp;
        bit           ev;
        logic [1:0]   ee;
    } vec_t;

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[223:0], $urandom()};
        return v;
    endfunction

    function automatic vec_t dflt();
        vec_t v;
        v.u1 = 256'h1111_2222_3333_4444_5555;
        v.u2 = 256'h9999_8888_7777_6666;
        v.r = 256'h1234; v.s = 256'h99;
        v.qx = 256'hC0FFEE_0001; v.qy = 256'hBEEF_0002; v.qinf = 0;
        v.lat1 = 10; v.lat2 = 10; v.lat3 = 5;
        v.rx = 256'h1234; v.rinf = 0; v.sminf = 0; v.inj = 0;
        v.has_exp = 1; v.ev = 1; v.ee = 2'd0;
        return v;
    endfunction

    // Outcome from the verification rules: error priority, wait budget per stage,
    // and acceptance as (R.x mod n == r) for a finite R.
    function automatic void model(input vec_t v, output bit ev, output logic [1:0] ee,
                                  output int off, output int nsm, output int npa);
        int lat[3];
        int entry;
        ev = 0; ee = 2'd0; nsm = 0; npa = 0; off = 2;
        if (v.r == 0 || v.r >= N || v.s == 0 || v.s >= N) begin ee = 2'd1; return; end
        if (v.qinf) begin ee = 2'd2; return; end
        lat[0] = v.lat1; lat[1] = v.lat2; lat[2] = v.lat3;
        entry = 3;                           // first wait state begins 3 cycles after start
        for (int st = 0; st < 3; st++) begin
            if (st < 2) nsm++; else npa++;
            if (lat[st] == 0 || lat[st] > TMOI) begin
                ee  = 2'd3;
                off = entry + TMOI;
                return;
            end
            entry = entry + lat[st] + 1;     // result cycle + 2 = next wait entry
        end
        off = entry + 1;
        ev  = !v.rinf && ((v.rx % N) == v.r);
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        bit           ev;
        logic [1:0]   ee;
        int           off, nsm, npa, d, cs, cp;
        bit           seen;
        logic [255:0] sk[2], spx[2], spy[2];
        bit           spi[2];
        logic [255:0] px1, py1, px2, py2;
        bit           pi1, pi2;
        model(v, ev, ee, off, nsm, npa);
        if (v.has_exp) begin ev = v.ev; ee = v.ee; end
        lat1_cfg = v.lat1; lat2_cfg = v.lat2; lat3_cfg = v.lat3;
        rx_cfg = v.rx; rinf_cfg = v.rinf; sminf_cfg = v.sminf;
        seen = 0; d = -1; cs = 0; cp = 0;
        px1 = '0; py1 = '0; px2 = '0; py2 = '0; pi1 = 0; pi2 = 0;
        @(negedge clk);
        sm_calls = 0;
        u1 = v.u1; u2 = v.u2; r = v.r; s = v.s; Qx = v.qx; Qy = v.qy; Qinf = v.qinf;
        start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = (k == v.inj);
            if (k == v.inj) begin u1 = ~v.u1; r = '0; Qinf = 1'b1; end
            if (k == 1) chk({tag, "_busy_on"}, busy, 1);
            if (sm_start) begin
                if (cs < 2) begin sk[cs] = sm_k; spx[cs] = sm_Px; spy[cs] = sm_Py; spi[cs] = sm_Pinf; end
                cs++;
            end
            if (pa_start) begin
                px1 = pa_x1; py1 = pa_y1; px2 = pa_x2; py2 = pa_y2; pi1 = pa_inf1; pi2 = pa_inf2;
                cp++;
            end
            if (done) begin d = k; seen = 1; break; end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, d, off);
        chk({tag, "_valid"}, valid, ev);
        chk({tag, "_err"}, err, ee);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_n_sm_start"}, cs, nsm);
        chk({tag, "_n_pa_start"}, cp, npa);
        if (nsm >= 1 && cs >= 1) begin
            chk({tag, "_sm1_k"}, sk[0], v.u1);
            chk({tag, "_sm1_P"}, {spx[0] ^ GX, spy[0] ^ GY}, 0);
            chk({tag, "_sm1_inf"}, spi[0], 0);
        end
        if (nsm >= 2 && cs >= 2) begin
            chk({tag, "_sm2_k"}, sk[1], v.u2);
            chk({tag, "_sm2_Px"}, spx[1], v.qx);
            chk({tag, "_sm2_Py"}, spy[1], v.qy);
            chk({tag, "_sm2_inf"}, spi[1], 0);
        end
        if (npa >= 1 && cp >= 1) begin
            chk({tag, "_pa_x1"}, px1, v.u1 ^ MASK);
            chk({tag, "_pa_y1"}, py1, ~v.u1);
            chk({tag, "_pa_x2"}, px2, v.u2 ^ MASK);
            chk({tag, "_pa_y2"}, py2, ~v.u2);
            chk({tag, "_pa_inf"}, {pi1, pi2}, {v.sminf, v.sminf});
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_valid_held"}, valid, ev);
        chk({tag, "_err_held"}, err, ee);
        @(negedge clk);
    endtask

    vec_t tbl[17];

    initial begin
        for (int i = 0; i < 17; i++) tbl[i] = dflt();
        tbl[0].r = 256'd0;                   tbl[0].ev = 0; tbl[0].ee = 2'd1;
        tbl[1].s = N;                        tbl[1].ev = 0; tbl[1].ee = 2'd1;
        tbl[2].r = N;                        tbl[2].ev = 0; tbl[2].ee = 2'd1;
        tbl[3].s = 256'd0;                   tbl[3].ev = 0; tbl[3].ee = 2'd1;
        tbl[4].r = 256'd1; tbl[4].s = 256'd1; tbl[4].qinf = 1; tbl[4].ev = 0; tbl[4].ee = 2'd2;
        // tbl[5]: nominal accept with x = r = 0x1234
        tbl[6].r = 256'h1235;               tbl[6].ev = 0;
        tbl[7].rx = N + 256'd5; tbl[7].r = 256'd5;
        tbl[8].rinf = 1; tbl[8].rx = 256'h77; tbl[8].r = 256'h77; tbl[8].ev = 0;
        tbl[9].lat1 = 0;                     tbl[9].ev = 0; tbl[9].ee = 2'd3;
        tbl[10].lat1 = 20;                   // result lands in the expiry cycle
        tbl[11].lat1 = 21;                   tbl[11].ev = 0; tbl[11].ee = 2'd3;
        tbl[12].lat2 = 0;                    tbl[12].ev = 0; tbl[12].ee = 2'd3;
        tbl[13].lat3 = 0;                    tbl[13].ev = 0; tbl[13].ee = 2'd3;
        tbl[14].inj = 18;                    // extra start while waiting on the second multiply
        tbl[15].sminf = 1;
        tbl[16].r = N - 256'd1; tbl[16].s = N - 256'd1; tbl[16].rx = N - 256'd1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_sm_start", sm_start, 0);
        chk("rst_pa_start", pa_start, 0);
        chk("rst_sm_k", sm_k, 0);
        chk("rst_pa_x1", pa_x1, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Randomized runs against the reference model
        for (int i = 0; i < 24; i++) begin
            vec_t v;
            v = dflt();
            v.has_exp = 0;
            v.u1 = rnd256(); v.u2 = rnd256(); v.qx = rnd256(); v.qy = rnd256();
            v.qinf = ($urandom_range(0, 7) == 0);
            v.s = (rnd256() >> 1) | 256'd1;
            v.rx = ($urandom_range(0, 2) == 0) ? (N + 256'($urandom())) : (rnd256() >> 1);
            v.r = ($urandom_range(0, 3) == 0) ? (rnd256() >> 1) : (v.rx % N);
            v.rinf = ($urandom_range(0, 5) == 0);
            v.sminf = $urandom_range(0, 1);
            v.lat1 = $urandom_range(1, 12); v.lat2 = $urandom_range(1, 12); v.lat3 = $urandom_range(1, 12);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset while waiting on point_add, then a clean run
        begin
            bit pa_seen;
            pa_seen = 0;
            lat1_cfg = 10; lat2_cfg = 10; lat3_cfg = 15;
            @(negedge clk);
            sm_calls = 0;
            u1 = tbl[5].u1; u2 = tbl[5].u2; r = tbl[5].r; s = tbl[5].s;
            Qx = tbl[5].qx; Qy = tbl[5].qy; Qinf = 1'b0;
            start = 1'b1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (pa_start) begin pa_seen = 1; break; end
            end
            chk("rstwa_pa_seen", pa_seen, 1);
            @(negedge clk);
            chk("rstwa_busy_before", busy, 1);
            #2 rst = 1'b1;
            #1;
            chk("rstwa_busy", busy, 0);
            chk("rstwa_done", done, 0);
            chk("rstwa_pa_x1", pa_x1, 0);
            chk("rstwa_sm_k", sm_k, 0);
            @(negedge clk);
            @(negedge clk);
            #1 rst = 1'b0;
            run_vec(tbl[5], "after_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
